// File: rtl/pc_stack_ctrl.sv
// rtl/pc_stack_ctrl.sv - program-counter sequencer driving the return-address stack
module pc_stack_ctrl #(
  parameter int                ADDR_W       = 12,
  parameter int                DEPTH        = 8,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  localparam int               DEPTH_W      = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic               is_call_i,
  input  logic               is_ret_i,
  input  logic               is_jump_i,
  input  logic [ADDR_W-1:0]  target_i,
  input  logic               stack_full_i,
  input  logic [ADDR_W-1:0]  pop_data_i,
  input  logic               clear_fault_i,
  output logic               push_enbl_o,
  output logic               pop_enbl_o,
  output logic [ADDR_W-1:0]  push_data_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               busy_o,
  output logic               overflow_o,
  output logic               underflow_o,
  output logic [DEPTH_W-1:0] depth_o
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
  localparam logic [ADDR_W-1:0]  PC_ONE    = ADDR_W'(1);

  // PUSH and POP each last one cycle; LOAD is where the popped return address lands in PC.
  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_PUSH  = 3'd1,
    ST_POP   = 3'd2,
    ST_LOAD  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   push_data_q, push_data_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic                push_enbl_q, push_enbl_d;
  logic                pop_enbl_q, pop_enbl_d;
  logic                busy_q, busy_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;

  logic                stack_empty;
  logic                stack_no_room;
  logic [ADDR_W-1:0]   pc_next_seq;

  assign stack_empty   = (depth_q == '0);
  assign stack_no_room = (depth_q == DEPTH_MAX) || stack_full_i;
  assign pc_next_seq   = pc_q + PC_ONE;

  // State and output registers; reset aborts any sequence in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_VECTOR;
      push_data_q <= '0;
      depth_q     <= '0;
      push_enbl_q <= 1'b0;
      pop_enbl_q  <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      push_data_q <= push_data_d;
      depth_q     <= depth_d;
      push_enbl_q <= push_enbl_d;
      pop_enbl_q  <= pop_enbl_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Next-state decode: RET beats CALL beats JUMP beats sequential; decode is only seen in RUN.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    push_data_d = push_data_q;
    depth_d     = depth_q;
    push_enbl_d = 1'b0;
    pop_enbl_d  = 1'b0;
    busy_d      = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    case (state_q)
      ST_RUN: begin
        if (enable_i) begin
          if (is_ret_i) begin
            if (stack_empty) begin
              underflow_d = 1'b1;
              state_d     = ST_FAULT;
            end else begin
              pop_enbl_d = 1'b1;
              busy_d     = 1'b1;
              depth_d    = depth_q - DEPTH_ONE;
              state_d    = ST_POP;
            end
          end else if (is_call_i) begin
            if (stack_no_room) begin
              overflow_d = 1'b1;
              state_d    = ST_FAULT;
            end else begin
              push_enbl_d = 1'b1;
              push_data_d = pc_next_seq;
              pc_d        = target_i;
              busy_d      = 1'b1;
              depth_d     = depth_q + DEPTH_ONE;
              state_d     = ST_PUSH;
            end
          end else if (is_jump_i) begin
            pc_d = target_i;
          end else begin
            pc_d = pc_next_seq;
          end
        end
      end

      ST_PUSH: begin
        state_d = ST_RUN;
      end

      // Stack presents the popped word during LOAD, so keep the decoder held one more cycle.
      ST_POP: begin
        busy_d  = 1'b1;
        state_d = ST_LOAD;
      end

      ST_LOAD: begin
        pc_d    = pop_data_i;
        state_d = ST_RUN;
      end

      ST_FAULT: begin
        if (clear_fault_i) begin
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
          state_d     = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign push_enbl_o = push_enbl_q;
  assign pop_enbl_o  = pop_enbl_q;
  assign push_data_o = push_data_q;
  assign pc_o        = pc_q;
  assign busy_o      = busy_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
  assign depth_o     = depth_q;

endmodule

// File: tb/tb_pc_stack_ctrl.sv
// tb/tb_pc_stack_ctrl.sv - self-checking bench for pc_stack_ctrl
module tb_pc_stack_ctrl;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        is_call = 1'b0;
  logic        is_ret = 1'b0;
  logic        is_jump = 1'b0;
  logic [11:0] target = '0;
  logic        stack_full = 1'b0;
  logic [11:0] pop_data = '0;
  logic        clear_fault = 1'b0;
  logic        push_enbl;
  logic        pop_enbl;
  logic [11:0] push_data;
  logic [11:0] pc;
  logic        busy;
  logic        overflow;
  logic        underflow;
  logic [3:0]  depth;

  int n_tests = 0;
  int n_fail  = 0;

  pc_stack_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_VECTOR(12'h000)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .is_call_i(is_call),
    .is_ret_i(is_ret), .is_jump_i(is_jump), .target_i(target),
    .stack_full_i(stack_full), .pop_data_i(pop_data), .clear_fault_i(clear_fault),
    .push_enbl_o(push_enbl), .pop_enbl_o(pop_enbl), .push_data_o(push_data),
    .pc_o(pc), .busy_o(busy), .overflow_o(overflow), .underflow_o(underflow),
    .depth_o(depth)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] pc;
    logic [3:0]  depth;
    logic        push;
    logic        pop;
    logic        busy;
    logic        ovf;
    logic        unf;
    logic [11:0] pdata;
  } snap_t;

  snap_t       cur;
  snap_t       pend[$];
  bit          m_fault;
  logic [11:0] m_stack[$];
  logic [11:0] emu[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cur.pc = 12'h000; cur.depth = 0; cur.push = 0; cur.pop = 0;
    cur.busy = 0; cur.ovf = 0; cur.unf = 0; cur.pdata = 12'h000;
    pend.delete();
    m_stack.delete();
    emu.delete();
    m_fault = 0;
    pop_data = '0;
  endtask

  // Transaction-level view: an accepted CALL/RET queues the whole sequence of
  // cycle snapshots it produces; inputs are only consulted when nothing is queued.
  task automatic model_edge();
    snap_t n, s2, s3;
    logic [11:0] ra;
    if (pend.size() > 0) begin
      cur = pend.pop_front();
    end else begin
      n = cur; n.push = 0; n.pop = 0; n.busy = 0;
      if (m_fault) begin
        if (clear_fault) begin n.ovf = 0; n.unf = 0; m_fault = 0; end
      end else if (enable) begin
        if (is_ret) begin
          if (m_stack.size() == 0) begin
            n.unf = 1; m_fault = 1;
          end else begin
            n.pop = 1; n.busy = 1; n.depth = cur.depth - 1;
            s2 = n; s2.pop = 0;
            s3 = s2; s3.busy = 0; s3.pc = m_stack.pop_back();
            pend.push_back(s2);
            pend.push_back(s3);
          end
        end else if (is_call) begin
          if (m_stack.size() == DEPTH || stack_full) begin
            n.ovf = 1; m_fault = 1;
          end else begin
            ra = cur.pc + 12'd1;
            m_stack.push_back(ra);
            n.push = 1; n.busy = 1; n.pdata = ra; n.pc = target; n.depth = cur.depth + 1;
            s2 = n; s2.push = 0; s2.busy = 0;
            pend.push_back(s2);
          end
        end else if (is_jump) begin
          n.pc = target;
        end else begin
          n.pc = cur.pc + 12'd1;
        end
      end
      cur = n;
    end
  endtask

  task automatic compare_all();
    chk("pc", pc, cur.pc);
    chk("depth", depth, cur.depth);
    chk("push_enbl", push_enbl, cur.push);
    chk("pop_enbl", pop_enbl, cur.pop);
    chk("busy", busy, cur.busy);
    chk("overflow", overflow, cur.ovf);
    chk("underflow", underflow, cur.unf);
    if (cur.push) chk("push_data", push_data, cur.pdata);
    chk("strobe_excl", push_enbl & pop_enbl, 1'b0);
  endtask

  // One clock: model consumes current inputs, DUT clocks, stack emulator reacts, compare.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    if (push_enbl) emu.push_back(push_data);
    if (pop_enbl) begin
      if (emu.size() > 0) pop_data = emu.pop_back();
      else pop_data = 12'($urandom);
    end
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #3;
    chk("rst_pc", pc, 12'h000);
    chk("rst_depth", depth, 4'd0);
    chk("rst_push", push_enbl, 1'b0);
    chk("rst_pop", pop_enbl, 1'b0);
    chk("rst_pdata", push_data, 12'h000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_flags", {overflow, underflow}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    enable = 0; is_call = 0; is_ret = 0; is_jump = 0; clear_fault = 0; stack_full = 0;
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    do_reset();

    // Sequential fetch and wrap
    enable = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("seq_pc", pc, i + 1);
    end
    is_jump = 1; target = 12'hFFE; step(); chk("jump_pc", pc, 12'hFFE);
    is_jump = 0; step(); chk("wrap_fff", pc, 12'hFFF);
    step(); chk("wrap_000", pc, 12'h000);

    // CALL then RET
    is_jump = 1; target = 12'h010; step();
    is_jump = 0; is_call = 1; target = 12'h200; step();
    chk("call_push", push_enbl, 1'b1);
    chk("call_pdata", push_data, 12'h011);
    chk("call_pc", pc, 12'h200);
    chk("call_depth", depth, 4'd1);
    is_call = 0; is_jump = 1; target = 12'h777; step();
    chk("push_ignored_pc", pc, 12'h200);
    is_jump = 0; is_ret = 1; step();
    chk("ret_pop", pop_enbl, 1'b1);
    chk("ret_depth", depth, 4'd0);
    is_ret = 0; step();
    chk("ret_busy", busy, 1'b1);
    step();
    chk("ret_pc", pc, 12'h011);

    // Nested calls to full, overflow, clear
    for (int i = 0; i < DEPTH; i++) begin
      enable = 1; is_call = 1; target = 12'h100 + 12'(i); step();
      enable = 0; is_call = 0; step();
    end
    chk("full_depth", depth, 4'd8);
    enable = 1; is_call = 1; target = 12'hABC; step();
    chk("ovf_push", push_enbl, 1'b0);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_pc", pc, 12'h107);
    is_call = 0; is_jump = 1; target = 12'h555; step();
    chk("fault_frozen_pc", pc, 12'h107);
    is_jump = 0; clear_fault = 1; step();
    chk("clear_ovf", overflow, 1'b0);
    chk("clear_depth", depth, 4'd8);
    clear_fault = 0;

    // Underflow from reset
    idle_inputs();
    do_reset();
    enable = 1; is_ret = 1; step();
    chk("unf_pop", pop_enbl, 1'b0);
    chk("unf_flag", underflow, 1'b1);
    is_ret = 0; is_jump = 1; target = 12'h055; step();
    chk("unf_frozen_pc", pc, 12'h000);
    is_jump = 0; clear_fault = 1; step();
    chk("clear_unf", underflow, 1'b0);
    clear_fault = 0;

    // CALL+RET together at depth 2
    is_call = 1; target = 12'h300; step();
    is_call = 0; step();
    is_call = 1; target = 12'h400; step();
    is_call = 0; step();
    is_call = 1; is_ret = 1; step();
    chk("both_pop", pop_enbl, 1'b1);
    chk("both_push", push_enbl, 1'b0);
    chk("both_depth", depth, 4'd1);
    is_call = 0; is_ret = 0; step(); step();
    chk("both_pc", pc, 12'h301);

    // Reset during POP
    is_ret = 1; step();
    chk("pre_rst_pop", pop_enbl, 1'b1);
    idle_inputs();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_strobes", {push_enbl, pop_enbl}, 2'b00);
      chk("post_rst_pc", pc, 12'h000);
    end

    // Randomised traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        idle_inputs();
        do_reset();
      end
      enable      = ($urandom_range(0, 9) < 8);
      is_ret      = ($urandom_range(0, 99) < 18);
      is_call     = ($urandom_range(0, 99) < 28);
      is_jump     = ($urandom_range(0, 99) < 15);
      clear_fault = ($urandom_range(0, 9) < 3);
      target      = 12'($urandom);
      stack_full  = (emu.size() >= DEPTH) || ($urandom_range(0, 19) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_stack_ctrl.md
Name: pc_stack_ctrl

Overview:
Program-counter sequencer that drives the 12-bit return-address stack as its initiator. It issues one push per CALL, carrying return address PC+1. It issues one pop per RET and reloads PC from the popped data one cycle later. It keeps its own depth count and reports overflow and underflow faults, because the stack only reports full. It sits between the instruction decoder and the stack in the RISC core fetch path.

Parameters:
ADDR_W, 12, PC / return-address width; must match stack data width
DEPTH, 8, stack entries; depth counter range 0..DEPTH
RESET_VECTOR, 12'h000, PC value after reset

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
Enable  in  1  advance PC / accept decode this cycle
IsCall  in  1  decoded CALL
IsRet  in  1  decoded RET
IsJump  in  1  decoded JUMP
Target  in  ADDR_W  CALL/JUMP destination
StackFull  in  1  full flag from stack
PopData  in  ADDR_W  stack pop data, valid the cycle after PopEnbl
ClearFault  in  1  leave FAULT state, clear fault flags
PushEnbl  out  1  push strobe to stack, one cycle
PopEnbl  out  1  pop strobe to stack, one cycle
PushData  out  ADDR_W  return address for push
PC  out  ADDR_W  current program counter
Busy  out  1  multi-cycle CALL/RET in progress; decoder must hold
Overflow  out  1  sticky: CALL attempted while full
Underflow  out  1  sticky: RET attempted while empty
Depth  out  clog2(DEPTH+1)  current entries pushed

Behaviour:
- All outputs are registered.
- Reset (async): PC=RESET_VECTOR, Depth=0, PushEnbl=PopEnbl=0, PushData=0, Busy=0, Overflow=Underflow=0, state RUN. Reset mid-sequence aborts it; no strobe is emitted after Reset deasserts.
- States: RUN, PUSH, POP, LOAD, FAULT.
- RUN, Enable=0: hold everything.
- RUN, Enable=1, decode priority is IsRet > IsCall > IsJump > sequential.
  - Sequential: PC<=PC+1, modulo 2^ADDR_W. 12'hFFF wraps to 12'h000.
  - JUMP: PC<=Target in one cycle.
  - CALL with Depth<DEPTH and StackFull=0: go to PUSH. PushEnbl=1 and PushData=PC+1 (mod 2^ADDR_W) for exactly one cycle. PC<=Target. Depth+1. Busy=1 for that cycle. Return to RUN.
  - CALL with Depth==DEPTH or StackFull=1: no push, PC unchanged, Overflow<=1, go to FAULT.
  - RET with Depth>0: go to POP. PopEnbl=1 for one cycle, Busy=1, Depth-1. Then LOAD: PC<=PopData, Busy=1. Then RUN. A RET sampled in cycle N gives PopEnbl in N+1, new PC visible in N+3.
  - RET with Depth==0: no pop, Underflow<=1, go to FAULT.
- Decode inputs are ignored while Busy=1.
- Enable is ignored in PUSH, POP and LOAD; a started sequence always completes.
- FAULT: PC, Depth and strobes are frozen. ClearFault=1 clears both flags and returns to RUN the next cycle; Depth is preserved. ClearFault outside FAULT has no effect.
- PushEnbl and PopEnbl are never both 1 in the same cycle.
- Depth never exceeds DEPTH and never goes below 0.

Test Plan:
- Reset, Enable=1 for 5 cycles, no decode -> PC 0,1,2,3,4,5. Preload PC=12'hFFE via JUMP -> next two PCs are FFF then 000.
- PC=12'h010, CALL Target=12'h200 -> next cycle PushEnbl=1, PushData=12'h011, PC=12'h200, Depth=1. Then RET with PopData=12'h011 -> PopEnbl one cycle later; PC=12'h011 two cycles after that; Depth=0.
- 8 nested CALLs -> Depth=8. A 9th CALL -> no PushEnbl, Overflow=1, FAULT, PC frozen. ClearFault -> RUN, Overflow=0, Depth=8.
- RET from reset (Depth=0) -> no PopEnbl, Underflow=1. Decode ignored until ClearFault.
- IsCall and IsRet asserted together at Depth=2 -> pop sequence only, no PushEnbl, Depth=1.
- Assert Reset during POP -> PC=RESET_VECTOR, Depth=0, no LOAD, no further strobes.
